bar_graph_renderer: RTL

//  Parametrised N-bar spectrum renderer for the VGA path. Bar heights arrive from the spectrum/

---
 rtl/bar_graph_renderer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/bar_graph_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : bar_graph_renderer
//  Purpose  : N-bar spectrum overlay for the VGA path with frame-synchronous
//             height latching and a peak-hold marker per bar.
//  Revision : 1.0 - initial release
// ============================================================================
module bar_graph_renderer #(
    parameter int NUM_BARS   = 10,
    parameter int BAR_WIDTH  = 53,
    parameter int BAR_GAP    = 10,
    parameter int X_START    = 10,
    parameter int SCREEN_H   = 480,
    parameter int HEIGHT_W   = 9,
    parameter int PEAK_HOLD  = 30,
    parameter int PEAK_DECAY = 4,
    parameter int IDX_W      = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Frame_Start,
    input  logic                Height_Valid,
    input  logic [IDX_W-1:0]    Height_Idx,
    input  logic [HEIGHT_W-1:0] Height_Data,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    output logic [7:0]          Red,
    output logic [7:0]          Green,
    output logic [7:0]          Blue
);

    localparam int c_PITCH  = BAR_WIDTH + BAR_GAP;
    localparam int c_HOLD_W = $clog2(PEAK_HOLD + 1);

    logic [HEIGHT_W-1:0] r_shadow [NUM_BARS];
    logic [HEIGHT_W-1:0] r_active [NUM_BARS];
    logic [HEIGHT_W-1:0] r_peak   [NUM_BARS];
    logic [c_HOLD_W-1:0] r_hold   [NUM_BARS];

    logic [HEIGHT_W-1:0] w_clamped;
    logic                w_idx_ok;

    assign w_clamped = (32'(Height_Data) > SCREEN_H) ? HEIGHT_W'(SCREEN_H) : Height_Data;
    assign w_idx_ok  = (32'(Height_Idx) < NUM_BARS);

    // Shadow writes and the frame copy share an edge, so the copy naturally
    // sees the pre-write shadow value.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_BARS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
                r_peak[i]   <= '0;
                r_hold[i]   <= '0;
            end
        end else begin
            if (Height_Valid && w_idx_ok)
                r_shadow[Height_Idx] <= w_clamped;
            if (Frame_Start) begin
                for (int i = 0; i < NUM_BARS; i++) begin
                    r_active[i] <= r_shadow[i];
                    if (r_shadow[i] >= r_peak[i]) begin
                        r_peak[i] <= r_shadow[i];
                        r_hold[i] <= c_HOLD_W'(PEAK_HOLD);
                    end else if (r_hold[i] != '0) begin
                        r_hold[i] <= r_hold[i] - 1'b1;
                    end else if (32'(r_peak[i]) > PEAK_DECAY) begin
                        r_peak[i] <= ((r_peak[i] - HEIGHT_W'(PEAK_DECAY)) > r_shadow[i])
                                   ? (r_peak[i] - HEIGHT_W'(PEAK_DECAY)) : r_shadow[i];
                    end else begin
                        r_peak[i] <= r_shadow[i];
                    end
                end
            end
        end
    end

    // Stage 1: horizontal bar decode
    logic             w_hit;
    logic [IDX_W-1:0] w_bar;
    logic [31:0]      w_x_ext;

    assign w_x_ext = {22'd0, DrawX};

    always_comb begin
        w_hit = 1'b0;
        w_bar = '0;
        for (int i = NUM_BARS - 1; i >= 0; i--) begin
            if (w_x_ext >= 32'(X_START + i * c_PITCH) &&
                w_x_ext <= 32'(X_START + i * c_PITCH + BAR_WIDTH)) begin
                w_hit = 1'b1;
                w_bar = IDX_W'(i);
            end
        end
    end

    logic             r_s1_vld;
    logic             r_s1_hit;
    logic [IDX_W-1:0] r_s1_bar;
    logic [9:0]       r_s1_x;
    logic [9:0]       r_s1_y;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_s1_vld <= 1'b0;
            r_s1_hit <= 1'b0;
            r_s1_bar <= '0;
            r_s1_x   <= '0;
            r_s1_y   <= '0;
        end else begin
            r_s1_vld <= 1'b1;
            r_s1_hit <= w_hit;
            r_s1_bar <= w_bar;
            r_s1_x   <= DrawX;
            r_s1_y   <= DrawY;
        end
    end

    // Stage 2: vertical fill / peak test and colour select
    logic [HEIGHT_W-1:0] w_act;
    logic [HEIGHT_W-1:0] w_pk_h;
    logic [10:0]         w_y;
    logic [10:0]         w_fill_top;
    logic [10:0]         w_pk_top;
    logic                w_fill;
    logic                w_pk;
    logic [7:0]          w_bg_b;

    assign w_act      = r_active[r_s1_bar];
    assign w_pk_h     = r_peak[r_s1_bar];
    assign w_y        = {1'b0, r_s1_y};
    assign w_fill_top = 11'(SCREEN_H) - 11'(w_act);
    assign w_pk_top   = 11'(SCREEN_H) - 11'(w_pk_h);
    assign w_fill     = r_s1_hit && (w_act != '0) && (w_y >= w_fill_top) && (w_y < 11'(SCREEN_H));
    assign w_pk       = r_s1_hit && (w_pk_h != '0) && (w_y >= w_pk_top) &&
                        (w_y <= w_pk_top + 11'd1) && (w_y < 11'(SCREEN_H));
    assign w_bg_b     = 8'h7F - {1'b0, r_s1_x[9:3]};

    always_ff @(posedge Clk) begin
        if (Reset || !r_s1_vld) begin
            Red   <= 8'h00;
            Green <= 8'h00;
            Blue  <= 8'h00;
        end else if (w_pk) begin
            Red   <= 8'hFF;
            Green <= 8'hFF;
            Blue  <= 8'hFF;
        end else if (w_fill) begin
            Red   <= 8'hFF;
            Green <= 8'h55;
            Blue  <= 8'h00;
        end else begin
            Red   <= 8'h00;
            Green <= 8'h00;
            Blue  <= w_bg_b;
        end
    end

endmodule
`default_nettype wire
